// File: rtl/msx_audio_mixer.sv
// Time-multiplexed N-channel signed mixer: per-channel gain/mute, one MAC per cycle, saturating output.
// Latency: NUM_CH+1 clk21m edges from the sampled strobe to the audio_out update (valid pulse).
// Backpressure: none; a strobe arriving while busy is dropped and latches the sticky overrun flag.
module msx_audio_mixer #(
  parameter int NUM_CH     = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 16,
  parameter int GAIN_W     = 4,
  parameter int GAIN_SHIFT = 2
) (
  input  logic                     clk21m,
  input  logic                     reset_n,
  input  logic                     sample_stb,
  input  logic [NUM_CH*IN_W-1:0]   ch_data,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  input  logic [NUM_CH-1:0]        ch_mute,
  output logic                     busy,
  output logic [OUT_W-1:0]         audio_out,
  output logic                     audio_valid,
  output logic                     clip,
  output logic                     overrun
);

  // Accumulator is wide enough that the full-scale sum of all channels never wraps.
  localparam int AW = IN_W + GAIN_W + 1 + $clog2(NUM_CH);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);
  localparam logic signed [AW-1:0] MAX_S = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_S = {{(AW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic signed [AW-1:0]       acc_q, acc_d;
  logic [NUM_CH*IN_W-1:0]     data_q, data_d;
  logic [NUM_CH*GAIN_W-1:0]   gain_q, gain_d;
  logic [NUM_CH-1:0]          mute_q, mute_d;
  logic [OUT_W-1:0]           out_q, out_d;
  logic                       clip_q, clip_d;
  logic                       valid_q, valid_d;
  logic                       ovr_q, ovr_d;

  logic signed [IN_W-1:0]     cur_data;
  logic [GAIN_W-1:0]          cur_gain;
  logic                       cur_mute;
  logic signed [AW-1:0]       ext_data, ext_gain, prod, shifted;

  // Select the current channel from the snapshot and form its signed x unsigned product.
  always_comb begin
    cur_data = data_q[idx_q*IN_W +: IN_W];
    cur_gain = gain_q[idx_q*GAIN_W +: GAIN_W];
    cur_mute = mute_q[idx_q];
    ext_data = {{(AW-IN_W){cur_data[IN_W-1]}}, cur_data};
    ext_gain = {{(AW-GAIN_W){1'b0}}, cur_gain};
    prod     = ext_data * ext_gain;
    shifted  = acc_q >>> GAIN_SHIFT;
  end

  // Next-state and datapath updates for the IDLE -> ACC -> SAT sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    gain_d  = gain_q;
    mute_d  = mute_q;
    out_d   = out_q;
    clip_d  = clip_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    if (sample_stb && (state_q != IDLE)) ovr_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (sample_stb) begin
          data_d  = ch_data;
          gain_d  = ch_gain;
          mute_d  = ch_mute;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = cur_mute ? acc_q : (acc_q + prod);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_d = SAT;
      end
      SAT: begin
        // Arithmetic shift drops the gain fraction (rounds toward -inf), then clamp.
        if (shifted > MAX_S) begin
          out_d  = MAX_S[OUT_W-1:0];
          clip_d = 1'b1;
        end else if (shifted < MIN_S) begin
          out_d  = MIN_S[OUT_W-1:0];
          clip_d = 1'b1;
        end else begin
          out_d  = shifted[OUT_W-1:0];
          clip_d = 1'b0;
        end
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any sample in flight.
  always_ff @(posedge clk21m or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      gain_q  <= '0;
      mute_q  <= '0;
      out_q   <= '0;
      clip_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      gain_q  <= gain_d;
      mute_q  <= mute_d;
      out_q   <= out_d;
      clip_q  <= clip_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign audio_out   = out_q;
  assign audio_valid = valid_q;
  assign clip        = clip_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Scoreboard bench: directed vectors on the default mixer, random vectors on a 3-channel narrow mixer.
// Expected results (value, clip, arrival cycle) are queued at stimulus time and popped on audio_valid.
// Both instances are checked by independent monitors sampling on the falling edge.
module tb_msx_audio_mixer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] out;
    logic        clip;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t rq[$];

  // Default instance (4 ch, 16-bit in/out)
  logic        reset_n, sample_stb;
  logic [63:0] ch_data;
  logic [15:0] ch_gain;
  logic [3:0]  ch_mute;
  logic        busy, audio_valid, clip, overrun;
  logic [15:0] audio_out;

  msx_audio_mixer dut (
    .clk21m(clk), .reset_n(reset_n), .sample_stb(sample_stb),
    .ch_data(ch_data), .ch_gain(ch_gain), .ch_mute(ch_mute),
    .busy(busy), .audio_out(audio_out), .audio_valid(audio_valid),
    .clip(clip), .overrun(overrun)
  );

  // Narrow instance (3 ch, 12-bit in, 10-bit out)
  logic        r_reset_n, r_stb;
  logic [35:0] r_data;
  logic [11:0] r_gain;
  logic [2:0]  r_mute;
  logic        r_busy, r_valid, r_clip, r_ovr;
  logic [9:0]  r_out;

  msx_audio_mixer #(.NUM_CH(3), .IN_W(12), .OUT_W(10), .GAIN_W(4), .GAIN_SHIFT(2)) dut_r (
    .clk21m(clk), .reset_n(r_reset_n), .sample_stb(r_stb),
    .ch_data(r_data), .ch_gain(r_gain), .ch_mute(r_mute),
    .busy(r_busy), .audio_out(r_out), .audio_valid(r_valid),
    .clip(r_clip), .overrun(r_ovr)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor for the default instance
  always @(negedge clk) begin
    if (audio_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("audio_out", 32'(audio_out), 32'(e.out));
        chk("clip", 32'(clip), 32'(e.clip));
        chk("latency_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Monitor for the narrow instance
  always @(negedge clk) begin
    if (r_valid === 1'b1) begin
      if (rq.size() == 0) begin
        chk("r_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = rq.pop_front();
        chk("r_audio_out", 32'(r_out), 32'(e.out));
        chk("r_clip", 32'(r_clip), 32'(e.clip));
        chk("r_latency_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Drive one strobe; caller is left at the falling edge just after E0.
  task automatic issue(input logic [63:0] d, input logic [15:0] g, input logic [3:0] m,
                       input logic [15:0] eo, input logic ec, input bit push);
    @(negedge clk);
    ch_data = d; ch_gain = g; ch_mute = m; sample_stb = 1'b1;
    if (push) q.push_back('{out: eo, clip: ec, at: cyc + 6});
    @(negedge clk);
    sample_stb = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; sample_stb = 1'b0; ch_data = '0; ch_gain = '0; ch_mute = '0;
    r_reset_n = 1'b0; r_stb = 1'b0; r_data = '0; r_gain = '0; r_mute = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out", 32'(audio_out), 32'd0);
    chk("rst_valid", 32'(audio_valid), 32'd0);
    chk("rst_clip", 32'(clip), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1; r_reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two unity channels: (0x1000+0x0800)*4 >>> 2 = 0x1800; busy spans 5 cycles
    issue({16'h0, 16'h0, 16'h0800, 16'h1000}, {4'd0, 4'd0, 4'd4, 4'd4}, 4'b1100, 16'h1800, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      chk("busy_high", 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("busy_low", 32'(busy), 32'd0);
    repeat (6) @(negedge clk);

    // Positive full scale: 4*32767*15 >>> 2 = 491505 -> clamp
    issue({4{16'h7FFF}}, {4{4'd15}}, 4'b0000, 16'h7FFF, 1'b1, 1);
    repeat (8) @(negedge clk);
    // Negative full scale: 4*(-32768)*4 >>> 2 = -131072 -> clamp
    issue({4{16'h8000}}, {4{4'd4}}, 4'b0000, 16'h8000, 1'b1, 1);
    repeat (8) @(negedge clk);
    // Floor rounding: -3*1 >>> 2 = -1
    issue({16'h0, 16'h0, 16'h0, 16'hFFFD}, {4'd0, 4'd0, 4'd0, 4'd1}, 4'b1110, 16'hFFFF, 1'b0, 1);
    repeat (8) @(negedge clk);
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Second strobe 2 cycles after the first is dropped
    issue({16'h0, 16'h0, 16'h0, 16'h0100}, {4'd0, 4'd0, 4'd0, 4'd4}, 4'b1110, 16'h0100, 1'b0, 1);
    @(negedge clk);
    ch_data = {4{16'h1234}}; ch_gain = {4{4'd15}}; ch_mute = 4'b0000; sample_stb = 1'b1;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (8) @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);

    // Inputs changed after E0 must not leak into the sample: 0x200*8 >>> 2 = 0x400
    issue({16'h0, 16'h0, 16'h0, 16'h0200}, {4'd0, 4'd0, 4'd0, 4'd8}, 4'b1110, 16'h0400, 1'b0, 1);
    ch_data = {4{16'h7FFF}};
    ch_gain = {4{4'd15}};
    repeat (8) @(negedge clk);

    // Reset asserted at E2 aborts the sample
    issue({16'h0, 16'h0, 16'h0, 16'h0300}, {4'd0, 4'd0, 4'd0, 4'd4}, 4'b1110, 16'h0, 1'b0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_out", 32'(audio_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_clip", 32'(clip), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);

    // Normal operation resumes after reset
    issue({16'h0, 16'h0, 16'h0800, 16'h1000}, {4'd0, 4'd0, 4'd4, 4'd4}, 4'b1100, 16'h1800, 1'b0, 1);
    repeat (8) @(negedge clk);

    // Random vectors on the narrow instance against an integer reference model
    for (int n = 0; n < 1000; n++) begin
      logic signed [11:0] d [3];
      logic [3:0]         g [3];
      logic [2:0]         m;
      int                 sum, s;
      logic [9:0]         o10;
      logic               c;
      sum = 0;
      m = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        d[k] = 12'($urandom);
        if (($urandom_range(0, 3)) == 0) d[k] = ($urandom_range(0, 1) == 1) ? 12'sh7FF : 12'sh800;
        g[k] = 4'($urandom_range(0, 15));
        if (!m[k]) sum += int'(d[k]) * int'(g[k]);
      end
      s = sum >>> 2;
      if (s > 511) begin
        o10 = 10'h1FF; c = 1'b1;
      end else if (s < -512) begin
        o10 = 10'h200; c = 1'b1;
      end else begin
        o10 = 10'(s); c = 1'b0;
      end
      @(negedge clk);
      r_data = {d[2], d[1], d[0]};
      r_gain = {g[2], g[1], g[0]};
      r_mute = m;
      r_stb  = 1'b1;
      rq.push_back('{out: {6'd0, o10}, clip: c, at: cyc + 5});
      @(negedge clk);
      r_stb = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("r_overrun_clear", 32'(r_ovr), 32'd0);

    // Bounded drain of outstanding expectations
    for (int t = 0; t < 50 && (q.size() + rq.size()) != 0; t++) @(negedge clk);
    chk("drain", 32'(q.size() + rq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
